// File: rtl/fp_dot_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the FP dot-product sequencer.
package fp_dot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int DEF_MUL_LAT = 3;
  localparam int DEF_ADD_LAT = 3;
  localparam int DEF_LEN_W   = 16;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/fp_dot_timer.sv
`timescale 1ns/1ps
// Loadable down-counter that parks at zero; o_zero marks the last cycle of a timed window.
module fp_dot_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fp_dot_seq.sv
`timescale 1ns/1ps
// Dot-product sequencer: clears the MAC, issues one pair per ADD_LAT+1 slot on a fixed phase, drains, captures the sum.
// in_ready only on phase-0 slots (phase never stalls); optional abort input under FP_DOT_SEQ_ABORT_EN.
module fp_dot_seq
  import fp_dot_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int ADD_LAT = DEF_ADD_LAT,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
`ifdef FP_DOT_SEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic [31:0]      mac_a,
  output logic [31:0]      mac_b,
  output logic             mac_clear,
  input  logic [31:0]      mac_out,
  output logic [31:0]      res_data,
  output logic             res_valid,
  output logic             done
);

  localparam int L     = ADD_LAT + 1;
  localparam int CLR   = MUL_LAT + ADD_LAT + 2;
  localparam int DRN   = MUL_LAT + ADD_LAT + 3;
  localparam int PH_W  = (L > 1) ? $clog2(L) : 1;
  localparam int TMR_W = $clog2(DRN + 1);

  state_t            r_state;
  logic [PH_W-1:0]   r_phase;
  logic [LEN_W-1:0]  r_rem;
  logic [31:0]       r_res_data;
  logic              r_res_valid;
  logic              r_done;
  logic              r_abort_clr;

  logic              w_abort;
  logic              w_hs;
  logic              w_last;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_zero;

`ifdef FP_DOT_SEQ_ABORT_EN
  assign w_abort = abort && (r_state inside {S_CLEAR, S_ISSUE, S_DRAIN});
`else
  assign w_abort = 1'b0;
`endif

  // Slots are fixed to phase 0 so every product joins the same accumulator chain.
  assign in_ready  = (r_state == S_ISSUE) && (r_phase == '0) && !w_abort;
  assign w_hs      = in_valid && in_ready;
  assign w_last    = w_hs && (r_rem == LEN_W'(1));
  assign mac_a     = w_hs ? in_a : FP_ZERO;
  assign mac_b     = w_hs ? in_b : FP_ZERO;
  assign mac_clear = reset || (r_state == S_CLEAR) || r_abort_clr;
  assign busy      = (r_state != S_IDLE);
  assign res_data  = r_res_data;
  assign res_valid = r_res_valid;
  assign done      = r_done;

  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = '0;
    if ((r_state == S_IDLE) && start && (len != '0)) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = TMR_W'(CLR - 1);
    end else if ((r_state == S_ISSUE) && w_last) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = TMR_W'(DRN - 1);
    end
  end

  fp_dot_timer #(.W(TMR_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_tmr_load),
    .i_val  (w_tmr_val),
    .o_zero (w_tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_phase     <= '0;
      r_rem       <= '0;
      r_res_data  <= FP_ZERO;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      r_done      <= 1'b0;
      r_abort_clr <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_abort_clr <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (len != '0) begin
                r_state     <= S_CLEAR;
                r_rem       <= len;
                r_res_valid <= 1'b0;
              end else begin
                r_state     <= S_DONE;
                r_res_data  <= FP_ZERO;
                r_res_valid <= 1'b1;
                r_done      <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            if (w_tmr_zero) begin
              r_state <= S_ISSUE;
              r_phase <= '0;
            end
          end
          S_ISSUE: begin
            r_phase <= (r_phase == PH_W'(L - 1)) ? '0 : r_phase + PH_W'(1);
            if (w_hs) begin
              r_rem <= r_rem - LEN_W'(1);
              if (w_last) r_state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (w_tmr_zero) begin
              r_res_data  <= mac_out;
              r_res_valid <= 1'b1;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_dot_seq.sv
`timescale 1ns/1ps
// Bench for fp_dot_seq with a behavioural pipelined FP MAC and a real-arithmetic dot-product reference.
module tb_fp_dot_seq;
  import fp_dot_pkg::*;

  localparam int MUL_LAT = DEF_MUL_LAT;
  localparam int ADD_LAT = DEF_ADD_LAT;
  localparam int LEN_W   = DEF_LEN_W;
  localparam int L       = ADD_LAT + 1;
  localparam int CLR     = MUL_LAT + ADD_LAT + 2;
  localparam int DRN     = MUL_LAT + ADD_LAT + 3;
  localparam int MAXC    = 400;

  logic             clk = 1'b0;
  logic             reset;
`ifdef FP_DOT_SEQ_ABORT_EN
  logic             abort;
`endif
  logic             start;
  logic [LEN_W-1:0] len;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_a, in_b;
  logic [31:0]      mac_a, mac_b;
  logic             mac_clear;
  logic [31:0]      mac_out;
  logic [31:0]      res_data;
  logic             res_valid;
  logic             done;

  always #5 clk = ~clk;

  fp_dot_seq #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .reset     (reset),
`ifdef FP_DOT_SEQ_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .len       (len),
    .busy      (busy),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_clear (mac_clear),
    .mac_out   (mac_out),
    .res_data  (res_data),
    .res_valid (res_valid),
    .done      (done)
  );

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real x);
    logic [63:0] d;
    int e;
    if (x == 0.0) return 32'h0;
    d = $realtobits(x);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // MAC environment: data reg, MUL_LAT multiplier stages, L-deep add/feedback loop, output reg.
  real m_dreg;
  real m_mul [MUL_LAT];
  real m_add [L];
  real m_out;

  always @(posedge clk) begin
    if (mac_clear) begin
      m_dreg <= 0.0;
      for (int i = 0; i < MUL_LAT; i++) m_mul[i] <= 0.0;
      for (int i = 0; i < L; i++) m_add[i] <= 0.0;
      m_out <= 0.0;
    end else begin
      m_dreg   <= f2r(mac_a) * f2r(mac_b);
      m_mul[0] <= m_dreg;
      for (int i = 1; i < MUL_LAT; i++) m_mul[i] <= m_mul[i-1];
      m_add[0] <= m_mul[MUL_LAT-1] + m_add[L-1];
      for (int i = 1; i < L; i++) m_add[i] <= m_add[i-1];
      m_out <= m_add[L-1];
    end
  end

  always_comb mac_out = r2f(m_out);

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] g_a [$];
  logic [31:0] g_b [$];
  int          g_issue [$];
  int          g_done_cyc, g_done_cnt, g_rdy_cnt, g_first_rdy, g_clr_cnt, g_mac_bad;
  bit          g_timeout;
  logic [31:0] g_res;
  bit          g_busy [MAXC];
  bit          g_rv   [MAXC];
  bit          g_clr  [MAXC];

  task automatic push_pair(input int va, input int vb);
    g_a.push_back(r2f(real'(va)));
    g_b.push_back(r2f(real'(vb)));
  endtask

  // vmode: 0 valid whenever data remains, 1 miss the first slot, 2 random valid.
  task automatic run_job(input int n, input int vmode, input int busy_rel,
                         input int rst_rel, input int abort_rel);
    int  idx;
    bit  v;
    idx = 0;
    g_issue.delete();
    g_done_cyc = -1; g_done_cnt = 0; g_rdy_cnt = 0; g_first_rdy = -1;
    g_clr_cnt = 0; g_mac_bad = 0; g_timeout = 1'b0; g_res = 32'hx;
    for (int rel = 0; rel < MAXC; rel++) begin
      @(posedge clk); #1;
      start = (rel == 0) || (rel == busy_rel) || (rel == busy_rel + 1);
      len   = (rel == 0) ? LEN_W'(n) : LEN_W'(5);
      reset = (rel == rst_rel);
`ifdef FP_DOT_SEQ_ABORT_EN
      abort = (rel == abort_rel);
`endif
      case (vmode)
        0:       v = (idx < n);
        1:       v = (idx < n) && (rel >= CLR + 2);
        default: v = (idx < n) && ($urandom_range(0, 2) != 0);
      endcase
      in_valid = v;
      in_a = v ? g_a[idx] : $urandom();
      in_b = v ? g_b[idx] : $urandom();
      @(negedge clk);
      g_busy[rel] = busy; g_rv[rel] = res_valid; g_clr[rel] = mac_clear;
      if (mac_clear) g_clr_cnt++;
      if (in_ready) begin
        g_rdy_cnt++;
        if (g_first_rdy < 0) g_first_rdy = rel;
      end
      if (in_valid && in_ready) begin
        if (mac_a !== in_a || mac_b !== in_b) g_mac_bad++;
        g_issue.push_back(rel);
        idx++;
      end else if (mac_a !== 32'h0 || mac_b !== 32'h0) begin
        g_mac_bad++;
      end
      if (done) begin
        g_done_cnt++;
        if (g_done_cyc < 0) begin g_done_cyc = rel; g_res = res_data; end
      end
      if (g_done_cyc >= 0 && rel >= g_done_cyc + 1) break;
      if (rst_rel >= 0 && rel >= rst_rel + 3) break;
      if (abort_rel >= 0 && rel >= abort_rel + 3) break;
      if (rel == MAXC - 1) g_timeout = 1'b1;
    end
    in_valid = 1'b0;
    g_a.delete();
    g_b.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mac_clear !== 1'b1) begin n_fail++; $display("FAIL reset_mac_clear: got %b want 1", mac_clear); end
    n_checks++; if ({busy, in_ready, res_valid, done} !== 4'b0) begin n_fail++; $display("FAIL reset_flags: busy/rdy/rv/done got %b want 0000", {busy, in_ready, res_valid, done}); end
    n_checks++; if ({mac_a, mac_b, res_data} !== 96'h0) begin n_fail++; $display("FAIL reset_data: mac_a %h mac_b %h res %h want 0", mac_a, mac_b, res_data); end
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    n_checks++; if (mac_clear !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset: mac_clear %b busy %b want 0 0", mac_clear, busy); end
  endtask

  task automatic test_basic();
    int i0, i1;
    push_pair(1, 3); push_pair(2, 4);
    run_job(2, 0, -1, -1, -1);
    i0 = (g_issue.size() > 0) ? g_issue[0] : -1;
    i1 = (g_issue.size() > 1) ? g_issue[1] : -1;
    n_checks++; if (g_timeout) begin n_fail++; $display("FAIL basic_timeout: no done within %0d cycles", MAXC); end
    n_checks++; if (i0 !== 9 || i1 !== 13 || g_issue.size() != 2) begin n_fail++; $display("FAIL basic_issue: got %0d,%0d (n=%0d) want 9,13", i0, i1, g_issue.size()); end
    n_checks++; if (g_rdy_cnt != 2 || g_first_rdy != CLR + 1) begin n_fail++; $display("FAIL basic_ready: count %0d first %0d want 2 %0d", g_rdy_cnt, g_first_rdy, CLR + 1); end
    n_checks++; if (g_done_cyc != 23) begin n_fail++; $display("FAIL basic_done_cyc: got %0d want 23", g_done_cyc); end
    n_checks++; if (g_res !== 32'h4130_0000) begin n_fail++; $display("FAIL basic_res: got %h want 41300000", g_res); end
    n_checks++; if (g_clr_cnt != CLR || g_clr[0] || !g_clr[1] || !g_clr[CLR]) begin n_fail++; $display("FAIL basic_clear: count %0d want %0d in cycles 1..%0d", g_clr_cnt, CLR, CLR); end
    n_checks++; if (g_mac_bad != 0) begin n_fail++; $display("FAIL basic_mac_ops: %0d bad cycles want 0", g_mac_bad); end
    n_checks++; if (!g_rv[g_done_cyc < 0 ? 0 : g_done_cyc] || g_done_cnt != 1) begin n_fail++; $display("FAIL basic_valid: rv %b done_cnt %0d want 1 1", g_rv[g_done_cyc < 0 ? 0 : g_done_cyc], g_done_cnt); end
  endtask

  task automatic test_stall();
    int i0, i1;
    push_pair(1, 3); push_pair(2, 4);
    run_job(2, 1, -1, -1, -1);
    i0 = (g_issue.size() > 0) ? g_issue[0] : -1;
    i1 = (g_issue.size() > 1) ? g_issue[1] : -1;
    n_checks++; if (g_rv[1] !== 1'b0) begin n_fail++; $display("FAIL stall_rv_cleared: got %b want 0", g_rv[1]); end
    n_checks++; if (i0 !== 13 || i1 !== 17) begin n_fail++; $display("FAIL stall_issue: got %0d,%0d want 13,17", i0, i1); end
    n_checks++; if (g_done_cyc != 27 || g_res !== 32'h4130_0000) begin n_fail++; $display("FAIL stall_result: done %0d res %h want 27 41300000", g_done_cyc, g_res); end
  endtask

  task automatic test_len0();
    run_job(0, 0, -1, -1, -1);
    n_checks++; if (g_done_cyc != 1 || g_done_cnt != 1) begin n_fail++; $display("FAIL len0_done: cyc %0d cnt %0d want 1 1", g_done_cyc, g_done_cnt); end
    n_checks++; if (g_res !== FP_ZERO || !g_rv[1]) begin n_fail++; $display("FAIL len0_res: res %h rv %b want 0 1", g_res, g_rv[1]); end
    n_checks++; if (g_clr_cnt != 0) begin n_fail++; $display("FAIL len0_clear: got %0d cycles want 0", g_clr_cnt); end
  endtask

  task automatic test_back_to_back();
    push_pair(2, 2);
    run_job(1, 0, -1, -1, -1);
    n_checks++; if (g_res !== 32'h4080_0000 || g_done_cyc != 19) begin n_fail++; $display("FAIL b2b_first: res %h done %0d want 40800000 19", g_res, g_done_cyc); end
    push_pair(1, 1);
    run_job(1, 0, -1, -1, -1);
    n_checks++; if (g_res !== FP_ONE || g_done_cyc != 19) begin n_fail++; $display("FAIL b2b_second: res %h done %0d want 3f800000 19", g_res, g_done_cyc); end
  endtask

  task automatic test_busy_start();
    push_pair(1, 3); push_pair(2, 4);
    run_job(2, 0, 10, -1, -1);
    n_checks++; if (g_res !== 32'h4130_0000 || g_done_cyc != 23 || g_done_cnt != 1) begin n_fail++; $display("FAIL busy_start: res %h done %0d cnt %0d want 41300000 23 1", g_res, g_done_cyc, g_done_cnt); end
  endtask

  task automatic test_reset_mid();
    push_pair(1, 3); push_pair(2, 4);
    run_job(2, 0, -1, 10, -1);
    n_checks++; if (!g_busy[10] || g_busy[11] || g_rv[11] || g_done_cnt != 0) begin n_fail++; $display("FAIL reset_mid: busy %b->%b rv %b done_cnt %0d want 1->0 0 0", g_busy[10], g_busy[11], g_rv[11], g_done_cnt); end
    push_pair(3, 1);
    run_job(1, 0, -1, -1, -1);
    n_checks++; if (g_res !== 32'h4040_0000 || g_done_cyc != 19) begin n_fail++; $display("FAIL reset_mid_next: res %h done %0d want 40400000 19", g_res, g_done_cyc); end
  endtask

  task automatic test_random();
    int n, va, vb, sum, last, misaligned;
    logic [31:0] want;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 6);
      sum = 0;
      for (int k = 0; k < n; k++) begin
        va = $urandom_range(0, 7);
        vb = $urandom_range(0, 7);
        sum += va * vb;
        push_pair(va, vb);
      end
      want = r2f(real'(sum));
      run_job(n, 2, -1, -1, -1);
      last = (g_issue.size() > 0) ? g_issue[$] : -100;
      misaligned = 0;
      foreach (g_issue[k]) if (((g_issue[k] - (CLR + 1)) % L) != 0 || g_issue[k] < CLR + 1) misaligned++;
      n_checks++; if (g_timeout || g_issue.size() != n) begin n_fail++; $display("FAIL rand%0d_count: issues %0d want %0d timeout %b", j, g_issue.size(), n, g_timeout); end
      n_checks++; if (g_res !== want) begin n_fail++; $display("FAIL rand%0d_res: got %h want %h", j, g_res, want); end
      n_checks++; if (g_done_cyc != last + DRN + 1 || g_done_cnt != 1) begin n_fail++; $display("FAIL rand%0d_done: cyc %0d cnt %0d want %0d 1", j, g_done_cyc, g_done_cnt, last + DRN + 1); end
      n_checks++; if (misaligned != 0 || g_mac_bad != 0) begin n_fail++; $display("FAIL rand%0d_slots: misaligned %0d mac_bad %0d want 0 0", j, misaligned, g_mac_bad); end
    end
  endtask

`ifdef FP_DOT_SEQ_ABORT_EN
  task automatic test_abort();
    push_pair(1, 1);
    run_job(1, 0, -1, -1, 12);
    n_checks++; if (!g_busy[12] || g_busy[13] || !g_clr[13] || g_rv[13] || g_done_cnt != 0) begin n_fail++; $display("FAIL abort_drain: busy %b->%b clr %b rv %b done_cnt %0d want 1->0 1 0 0", g_busy[12], g_busy[13], g_clr[13], g_rv[13], g_done_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b1; start = 1'b0; len = '0;
    in_valid = 1'b0; in_a = '0; in_b = '0;
`ifdef FP_DOT_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    test_reset();
    test_basic();
    test_stall();
    test_len0();
    test_back_to_back();
    test_busy_start();
    test_reset_mid();
    test_random();
`ifdef FP_DOT_SEQ_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_dot_seq.md
# fp_dot_seq

Sequencer for the floating-point multiply-accumulate datapath: computes the dot product of a streamed vector pair by feeding one operand pair at a time into the FP MAC. It clears the MAC before each job and paces issues to the MAC's accumulator feedback latency so that every product lands on a single accumulation chain. It then drains the pipeline and captures the sum. It sits between an operand-streaming source (valid/ready) and the MAC instance, which it owns exclusively.

## Interface
- MUL_LAT, 3, FP multiplier latency (data register to product), cycles
- ADD_LAT, 3, FP adder latency (adder inputs to sum before out register), cycles
- LEN_W, 16, width of vector length
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job request; sampled only in IDLE
- len  in  LEN_W  number of element pairs; sampled with start
- busy  out  1  high in any state other than IDLE
- in_valid  in  1  operand pair valid
- in_ready  out  1  operand pair accepted when in_valid&in_ready
- in_a, in_b  in  32  IEEE-754 single operands
- mac_a, mac_b  out  32  MAC operand inputs
- mac_clear  out  1  drives the MAC reset
- mac_out  in  32  MAC accumulator output
- res_data  out  32  captured dot product
- res_valid  out  1  res_data valid; held until the next accepted start
- done  out  1  one-cycle pulse when res_valid rises

## Operation
- Derived constants: L = ADD_LAT+1 (issue interval), CLR = MUL_LAT+ADD_LAT+2 (clear cycles), DRN = MUL_LAT+ADD_LAT+3 (last issue to result on mac_out).
- States: IDLE, CLEAR, ISSUE, DRAIN, DONE.
- IDLE:
  - start&&len!=0 -> CLEAR; latch len; clear res_valid.
  - start&&len==0 -> DONE with res_data=0.
- CLEAR: mac_clear=1 for CLR cycles, then -> ISSUE with phase=0.
- ISSUE:
  - Phase counter is free-running mod L and never stalls.
  - in_ready=1 only when phase==0.
  - On handshake: mac_a/mac_b=in_a/in_b for that cycle and decrement remaining.
  - Otherwise mac_a=mac_b=0.
  - A missed phase-0 slot waits a full L cycles; the counter does not slip, so every product stays on the same chain.
  - Remaining reaches 0 -> DRAIN.
- DRAIN: count DRN cycles from the last issue cycle; capture res_data<=mac_out -> DONE.
- DONE: done=1, res_valid<=1 for one cycle, then -> IDLE.
- mac_a/mac_b are 0 in every state except an ISSUE handshake cycle.
- start while busy is ignored.
- Reset values: busy=0, in_ready=0, mac_a=mac_b=0, mac_clear=1 (mac_clear = reset | state==CLEAR), res_data=0, res_valid=0, done=0, state=IDLE.
- Reset mid-job: return to IDLE immediately; partial sum discarded; no done pulse.

## Timing
- start accepted at cycle 0 -> mac_clear high in cycles 1..CLR -> first in_ready at cycle CLR+1.
- Consecutive issues are exactly k·L cycles apart (k≥1).
- Last issue at cycle t -> res_data/res_valid/done update at cycle t+DRN+1.
- Defaults: L=4, CLR=8, DRN=9.
- Minimum job latency for len=N with no stalls: 1+CLR+(N-1)·L+DRN+1 cycles from start to done.
- len==0: done at cycle 1.

## Configuration
- FP_DOT_SEQ_ABORT_EN defined:
  - Adds input abort (1 bit).
  - abort in CLEAR, ISSUE or DRAIN -> IDLE next cycle, with mac_clear=1 in that cycle.
  - No done pulse; res_valid stays 0.
  - abort in IDLE/DONE has no effect.
- Undefined: port absent; jobs always run to completion.

## Structure
- Package fp_dot_pkg holds:
  - the state enum;
  - default latency constants;
  - FP constants FP_ZERO=32'h0 and FP_ONE=32'h3F800000 used by the bench.
- One sub-module, fp_dot_timer: loadable down-counter with a zero flag, shared by CLEAR and DRAIN.
- The MAC is instantiated outside this block.

## Test plan
- [1.0,2.0]·[3.0,4.0] (0x3F800000,0x40000000 / 0x40400000,0x40800000), in_valid always high:
  - in_ready pulses at cycles 9 and 13;
  - done at cycle 23;
  - res_data=0x41300000 (11.0).
- Same vectors with in_valid low during the first phase-0 slot:
  - second issue waits one full L;
  - result still 0x41300000; done 4 cycles later.
- len=0 -> done at cycle 1, res_data=0, mac_clear never pulsed beyond reset.
- Back-to-back jobs: [2.0]·[2.0] then [1.0]·[1.0] -> results 0x40800000 then 0x3F800000; the second result has no carry-over from the first.
- start asserted while busy -> ignored; current job result unchanged.
- Reset asserted during ISSUE:
  - IDLE next cycle, res_valid=0, no done;
  - a new [3.0]·[1.0] job yields 0x40400000.
- With FP_DOT_SEQ_ABORT_EN: abort during DRAIN -> IDLE, res_valid=0, no done.
